// File: rtl/branch_cmp_pkg.sv
// Shared encodings for the branch/conditional-move comparator.
// Holds the MIPS opcode, REGIMM rt and SPECIAL funct values the decoder
// recognises, plus the cond_t enumeration of recognised conditions.
package branch_cmp_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // REGIMM sub-opcodes, instr[20:16]
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    // SPECIAL function codes, instr[5:0]
    localparam logic [5:0] FN_MOVZ    = 6'b001010;
    localparam logic [5:0] FN_MOVN    = 6'b001011;

    typedef enum logic [3:0] {
        COND_NONE,
        COND_BEQ,
        COND_BNE,
        COND_BLEZ,
        COND_BGTZ,
        COND_BLTZ,
        COND_BGEZ,
        COND_BLTZAL,
        COND_BGEZAL,
        COND_MOVZ,
        COND_MOVN
    } cond_t;

endpackage

// File: rtl/branch_cmp_decode.sv
// Combinational instruction decode and condition evaluation.
// Ports:
//   i_instr   - instruction word (op, rt, funct fields used)
//   i_data1   - forwarded rs value
//   i_data2   - forwarded rt value
//   o_cmp     - condition true (branch taken / move performed)
//   o_link    - instruction writes $31, regardless of o_cmp
//   o_is_cond - instruction is a recognised conditional
module branch_cmp_decode
    import branch_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [31:0]      i_instr,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    output logic             o_cmp,
    output logic             o_link,
    output logic             o_is_cond
);

    logic [5:0] w_op;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic       w_neg1;
    logic       w_zero1;
    logic       w_zero2;
    logic       w_unused;
    cond_t      w_cond;

    assign w_op     = i_instr[31:26];
    assign w_rt     = i_instr[20:16];
    assign w_funct  = i_instr[5:0];
    assign w_unused = ^{i_instr[25:21], i_instr[15:6]};

    assign w_neg1   = i_data1[WIDTH-1];
    assign w_zero1  = (i_data1 == '0);
    assign w_zero2  = (i_data2 == '0);

    always_comb begin
        w_cond = COND_NONE;
        case (w_op)
            OP_BEQ:  w_cond = COND_BEQ;
            OP_BNE:  w_cond = COND_BNE;
            OP_BLEZ: w_cond = COND_BLEZ;
            OP_BGTZ: w_cond = COND_BGTZ;
            OP_REGIMM: begin
                case (w_rt)
                    RT_BLTZ:   w_cond = COND_BLTZ;
                    RT_BGEZ:   w_cond = COND_BGEZ;
                    RT_BLTZAL: w_cond = COND_BLTZAL;
                    RT_BGEZAL: w_cond = COND_BGEZAL;
                    default:   w_cond = COND_NONE;
                endcase
            end
            OP_SPECIAL: begin
                case (w_funct)
                    FN_MOVZ: w_cond = COND_MOVZ;
                    FN_MOVN: w_cond = COND_MOVN;
                    default: w_cond = COND_NONE;
                endcase
            end
            default: w_cond = COND_NONE;
        endcase
    end

    always_comb begin
        o_cmp = 1'b0;
        case (w_cond)
            COND_BEQ:    o_cmp = (i_data1 == i_data2);
            COND_BNE:    o_cmp = (i_data1 != i_data2);
            COND_BLEZ:   o_cmp = w_neg1 || w_zero1;
            COND_BGTZ:   o_cmp = !w_neg1 && !w_zero1;
            COND_BLTZ:   o_cmp = w_neg1;
            COND_BLTZAL: o_cmp = w_neg1;
            COND_BGEZ:   o_cmp = !w_neg1;
            COND_BGEZAL: o_cmp = !w_neg1;
            COND_MOVZ:   o_cmp = w_zero2;
            COND_MOVN:   o_cmp = !w_zero2;
            default:     o_cmp = 1'b0;
        endcase
    end

    assign o_link    = (w_cond == COND_BLTZAL) || (w_cond == COND_BGEZAL);
    assign o_is_cond = (w_cond != COND_NONE);

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch / conditional-move comparator with valid/ready handshake,
// flush, and saturating taken/evaluated counters.
// Ports:
//   i_clk, i_reset                 - clock, async active-high reset
//   i_in_valid / o_in_ready        - request handshake
//   i_instr, i_data1, i_data2      - instruction and forwarded operands
//   i_tag_in / o_tag_out           - passthrough tag
//   i_flush                        - kill all in-flight entries
//   o_out_valid / i_out_ready      - result handshake
//   o_cmp_out, o_link, o_is_cond   - result fields
//   i_clr_cnt                      - clear both counters
//   o_taken_cnt, o_eval_cnt        - saturating performance counters
module branch_cmp_pipe
    import branch_cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAGW   = 32,
    parameter int unsigned CNTW   = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_instr,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic [TAGW-1:0]  i_tag_in,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_cmp_out,
    output logic             o_link,
    output logic             o_is_cond,
    output logic [TAGW-1:0]  o_tag_out,
    input  logic             i_clr_cnt,
    output logic [CNTW-1:0]  o_taken_cnt,
    output logic [CNTW-1:0]  o_eval_cnt
);

    localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

    logic w_en;
    logic w_accept;
    logic w_xfer;
    logic w_dec_cmp;
    logic w_dec_link;
    logic w_dec_is_cond;

    // Index 0 is the youngest stage, STAGES-1 drives the outputs.
    logic [STAGES-1:0]           r_valid;
    logic [STAGES-1:0]           r_cmp;
    logic [STAGES-1:0]           r_link;
    logic [STAGES-1:0]           r_is_cond;
    logic [STAGES-1:0][TAGW-1:0] r_tag;
    logic [CNTW-1:0]             r_taken_cnt;
    logic [CNTW-1:0]             r_eval_cnt;

    branch_cmp_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .i_instr   (i_instr),
        .i_data1   (i_data1),
        .i_data2   (i_data2),
        .o_cmp     (w_dec_cmp),
        .o_link    (w_dec_link),
        .o_is_cond (w_dec_is_cond)
    );

    // Single global stall: the whole pipe moves only when the output slot can drain.
    assign w_en       = !o_out_valid || i_out_ready;
    assign o_in_ready = w_en && !i_flush;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_xfer     = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid   <= '0;
            r_cmp     <= '0;
            r_link    <= '0;
            r_is_cond <= '0;
            r_tag     <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= '0;
            end else if (w_en) begin
                r_valid[0] <= w_accept;
                for (int i = 1; i < STAGES; i++) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
            // Payload shifts with the enable even for bubbles or flushed entries;
            // its contents only matter where the matching valid bit is set.
            if (w_en) begin
                r_cmp[0]     <= w_dec_cmp;
                r_link[0]    <= w_dec_link;
                r_is_cond[0] <= w_dec_is_cond;
                r_tag[0]     <= i_tag_in;
                for (int i = 1; i < STAGES; i++) begin
                    r_cmp[i]     <= r_cmp[i-1];
                    r_link[i]    <= r_link[i-1];
                    r_is_cond[i] <= r_is_cond[i-1];
                    r_tag[i]     <= r_tag[i-1];
                end
            end
        end
    end

    assign o_out_valid = r_valid[STAGES-1];
    assign o_cmp_out   = r_cmp[STAGES-1];
    assign o_link      = r_link[STAGES-1];
    assign o_is_cond   = r_is_cond[STAGES-1];
    assign o_tag_out   = r_tag[STAGES-1];

    // Counters saturate; a clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_taken_cnt <= '0;
            r_eval_cnt  <= '0;
        end else if (i_clr_cnt) begin
            r_taken_cnt <= '0;
            r_eval_cnt  <= '0;
        end else if (w_xfer) begin
            if (o_cmp_out && (r_taken_cnt != CntMax)) begin
                r_taken_cnt <= r_taken_cnt + CNTW'(1);
            end
            if (o_is_cond && (r_eval_cnt != CntMax)) begin
                r_eval_cnt <= r_eval_cnt + CNTW'(1);
            end
        end
    end

    assign o_taken_cnt = r_taken_cnt;
    assign o_eval_cnt  = r_eval_cnt;

endmodule
